// File: rtl/aes_iter_encrypt_if.sv
// Valid/ready bundle between a plaintext/key producer, a ciphertext consumer and the
// iterative AES engine. NK sets the key width (32*NK bits) and must match the engine.
interface aes_iter_encrypt_if #(
    parameter int unsigned NK = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [127:0]      in_data;
    logic [32*NK-1:0]  in_key;
    logic              out_valid;
    logic              out_ready;
    logic [127:0]      out_data;
    logic              busy;

    // Producer/consumer side
    modport master (
        output in_valid, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    // Engine side
    modport slave (
        input  in_valid, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/aes_iter_encrypt.sv
// Iterative AES encryption engine: one full round per clock, AES-128/192/256 selected by
// NK/NR (legal pairs 4/10, 6/12, 8/14). Block in on a valid/ready handshake, ciphertext
// out on a second valid/ready handshake; a new block may be accepted on the output
// handshake cycle, giving one block every NR+1 cycles.
module aes_iter_encrypt #(
    parameter int unsigned NK = 4,
    parameter int unsigned NR = 10
) (
    input  logic              clk,
    input  logic              reset,
    aes_iter_encrypt_if.slave bus
);

    localparam int unsigned KW  = 32 * NK;
    localparam int unsigned NW  = 4 * (NR + 1);
    localparam int unsigned FKW = 128 * (NR + 1);
    localparam logic [3:0]  NR4 = 4'(NR);

    typedef enum logic [1:0] {StIdle, StRound, StDone} st_e;

    // ------------------------------------------------------------------------------------
    // GF(2^8) and AES primitives
    // ------------------------------------------------------------------------------------

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    // S-box computed as the multiplicative inverse (x^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x3, x7, x15, x31, x63, x127, inv;
        x3   = gf_mul(gf_mul(x, x), x);
        x7   = gf_mul(gf_mul(x3, x3), x);
        x15  = gf_mul(gf_mul(x7, x7), x);
        x31  = gf_mul(gf_mul(x15, x15), x);
        x63  = gf_mul(gf_mul(x31, x31), x);
        x127 = gf_mul(gf_mul(x63, x63), x);
        inv  = gf_mul(x127, x127);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Byte b of the state lives at bits [127-8b -: 8]; byte index = row + 4*column
    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int unsigned b = 0; b < 16; b++) begin
            o[127-8*b -: 8] = sbox(s[127-8*b -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    // Full schedule, round 0 key in the most significant 128 bits
    function automatic logic [FKW-1:0] key_expand(input logic [KW-1:0] key);
        logic [31:0]    w [NW];
        logic [31:0]    t;
        logic [7:0]     rcon;
        logic [FKW-1:0] fk;
        rcon = 8'h01;
        for (int unsigned i = 0; i < NW; i++) begin
            if (i < NK) begin
                w[i] = key[KW-1-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % NK == 0) begin
                    t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
                    rcon = xtime(rcon);
                end else if (NK > 6 && i % NK == 4) begin
                    t = sub_word(t);
                end
                w[i] = w[i-NK] ^ t;
            end
        end
        for (int unsigned i = 0; i < NW; i++) begin
            fk[FKW-1-32*i -: 32] = w[i];
        end
        return fk;
    endfunction

    // ------------------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------------------

    st_e            st_q, st_d;
    logic [3:0]     rnd_q, rnd_d;
    logic [KW-1:0]  key_q, key_d;
    logic [127:0]   state_q, state_d;
    logic [127:0]   out_data_q, out_data_d;

    logic [FKW-1:0] full_keys;
    logic [127:0]   rk_round;
    logic [127:0]   init_state;
    logic [127:0]   sr_out;
    logic [127:0]   round_out;
    logic           last_round;
    logic           in_ready_c;
    int unsigned    rk_msb;

    // Round datapath: key schedule from the held key, one AES round on state_q
    always_comb begin
        full_keys  = key_expand(key_q);
        rk_msb     = FKW - 1 - 128 * 32'(rnd_q);
        rk_round   = full_keys[rk_msb -: 128];
        // On the capture cycle the round-0 key is simply the leading 128 key bits
        init_state = bus.in_data ^ bus.in_key[KW-1 -: 128];
        last_round = (rnd_q == NR4);
        sr_out     = shift_rows(sub_bytes(state_q));
        round_out  = (last_round ? sr_out : mix_columns(sr_out)) ^ rk_round;
    end

    // Next-state logic and handshake decode
    always_comb begin
        st_d       = st_q;
        rnd_d      = rnd_q;
        key_d      = key_q;
        state_d    = state_q;
        out_data_d = out_data_q;
        in_ready_c = 1'b0;

        unique case (st_q)
            StIdle: begin
                in_ready_c = 1'b1;
            end
            StRound: begin
                state_d = round_out;
                if (last_round) begin
                    out_data_d = round_out;
                    st_d       = StDone;
                end else begin
                    rnd_d = 4'(rnd_q + 4'd1);
                end
            end
            StDone: begin
                // A new block can only enter as the current result leaves
                in_ready_c = bus.out_ready;
                if (bus.out_ready) st_d = StIdle;
            end
            default: begin
                st_d = StIdle;
            end
        endcase

        if (in_ready_c && bus.in_valid) begin
            key_d   = bus.in_key;
            state_d = init_state;
            rnd_d   = 4'd1;
            st_d    = StRound;
        end
    end

    // State registers with synchronous reset; reset abandons any block in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            st_q       <= StIdle;
            rnd_q      <= 4'd0;
            key_q      <= '0;
            state_q    <= '0;
            out_data_q <= '0;
        end else begin
            st_q       <= st_d;
            rnd_q      <= rnd_d;
            key_q      <= key_d;
            state_q    <= state_d;
            out_data_q <= out_data_d;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = (st_q == StDone);
    assign bus.busy      = (st_q == StRound);
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_aes_iter_encrypt.sv
// Directed bench for the iterative AES engine: FIPS-197 vectors for all three key sizes,
// latency, backpressure, back-to-back streaming and mid-block reset.
module tb_aes_iter_encrypt;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    localparam logic [127:0] PT_A   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K128_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT128A = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [191:0] K192_A = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
    localparam logic [127:0] CT192A = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [255:0] K256_A =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT256A = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K128_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT128B = 128'h3925841d02dc09fbdc118597196a0b32;

    aes_iter_encrypt_if #(.NK(4)) b128 ();
    aes_iter_encrypt_if #(.NK(6)) b192 ();
    aes_iter_encrypt_if #(.NK(8)) b256 ();

    aes_iter_encrypt #(.NK(4), .NR(10)) u_dut128 (.clk(clk), .reset(reset), .bus(b128));
    aes_iter_encrypt #(.NK(6), .NR(12)) u_dut192 (.clk(clk), .reset(reset), .bus(b192));
    aes_iter_encrypt #(.NK(8), .NR(14)) u_dut256 (.clk(clk), .reset(reset), .bus(b256));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out128(input int exp_lat, input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!b128.out_valid && n < 40);
        n_vec++;
        if (n !== exp_lat) begin
            n_err++;
            $display("FAIL %s latency: got %0d cycles, expected %0d", name, n, exp_lat);
        end
    endtask

    // Accept one block on the 128-bit engine and check latency/result; optionally release it
    task automatic run128(input logic [127:0] pt, input logic [127:0] key,
                          input logic [127:0] ct, input bit release_out, input string name);
        b128.in_data   = pt;
        b128.in_key    = key;
        b128.in_valid  = 1'b1;
        b128.out_ready = 1'b0;
        n_vec++;
        if (b128.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s in_ready before accept: got %b, expected 1", name, b128.in_ready);
        end
        tick();
        b128.in_valid = 1'b0;
        b128.in_data  = '1;
        b128.in_key   = '1;
        wait_out128(10, name);
        n_vec++;
        if (b128.out_data !== ct) begin
            n_err++;
            $display("FAIL %s out_data: got %h, expected %h", name, b128.out_data, ct);
        end
        if (release_out) begin
            b128.out_ready = 1'b1;
            tick();
            b128.out_ready = 1'b0;
            n_vec++;
            if (b128.out_valid !== 1'b0 || b128.in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL %s after handshake: out_valid=%b in_ready=%b, expected 0/1",
                         name, b128.out_valid, b128.in_ready);
            end
        end
    endtask

    task automatic test_reset();
        n_vec++;
        if (b128.in_ready !== 1'b1 || b128.out_valid !== 1'b0 || b128.busy !== 1'b0 ||
            b128.out_data !== 128'h0) begin
            n_err++;
            $display("FAIL reset128: rdy=%b vld=%b busy=%b data=%h, expected 1/0/0/0",
                     b128.in_ready, b128.out_valid, b128.busy, b128.out_data);
        end
        n_vec++;
        if (b192.in_ready !== 1'b1 || b192.out_valid !== 1'b0 || b256.in_ready !== 1'b1 ||
            b256.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset192_256: rdy=%b/%b vld=%b/%b, expected 1/1 0/0",
                     b192.in_ready, b256.in_ready, b192.out_valid, b256.out_valid);
        end
    endtask

    task automatic test_aes128();
        run128(PT_A, K128_A, CT128A, 1'b1, "aes128_a");
        run128(PT_B, K128_B, CT128B, 1'b1, "aes128_b");
    endtask

    task automatic test_aes192();
        int n;
        b192.in_data  = PT_A;
        b192.in_key   = K192_A;
        b192.in_valid = 1'b1;
        tick();
        b192.in_valid = 1'b0;
        b192.in_data  = '0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!b192.out_valid && n < 40);
        n_vec++;
        if (n !== 12) begin
            n_err++;
            $display("FAIL aes192 latency: got %0d cycles, expected 12", n);
        end
        n_vec++;
        if (b192.out_data !== CT192A) begin
            n_err++;
            $display("FAIL aes192 out_data: got %h, expected %h", b192.out_data, CT192A);
        end
        b192.out_ready = 1'b1;
        tick();
        b192.out_ready = 1'b0;
    endtask

    task automatic test_aes256();
        int n;
        b256.in_data  = PT_A;
        b256.in_key   = K256_A;
        b256.in_valid = 1'b1;
        tick();
        b256.in_valid = 1'b0;
        b256.in_data  = '0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!b256.out_valid && n < 40);
        n_vec++;
        if (n !== 14) begin
            n_err++;
            $display("FAIL aes256 latency: got %0d cycles, expected 14", n);
        end
        n_vec++;
        if (b256.out_data !== CT256A) begin
            n_err++;
            $display("FAIL aes256 out_data: got %h, expected %h", b256.out_data, CT256A);
        end
        b256.out_ready = 1'b1;
        tick();
        b256.out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        run128(PT_B, K128_B, CT128B, 1'b0, "bp");
        // A new block is offered while the consumer stalls; it must not be taken
        b128.in_data  = PT_A;
        b128.in_key   = K128_A;
        b128.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_vec++;
            if (b128.out_valid !== 1'b1 || b128.out_data !== CT128B || b128.in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp hold %0d: vld=%b rdy=%b data=%h, expected 1/0/%h",
                         i, b128.out_valid, b128.in_ready, b128.out_data, CT128B);
            end
        end
        b128.in_valid  = 1'b0;
        b128.out_ready = 1'b1;
        tick();
        b128.out_ready = 1'b0;
        n_vec++;
        if (b128.out_valid !== 1'b0 || b128.in_ready !== 1'b1 || b128.busy !== 1'b0) begin
            n_err++;
            $display("FAIL bp release: vld=%b rdy=%b busy=%b, expected 0/1/0",
                     b128.out_valid, b128.in_ready, b128.busy);
        end
    endtask

    task automatic test_back_to_back();
        b128.out_ready = 1'b1;
        b128.in_valid  = 1'b1;
        b128.in_data   = PT_A;
        b128.in_key    = K128_A;
        tick();
        b128.in_data = PT_B;
        b128.in_key  = K128_B;
        wait_out128(10, "b2b_1");
        n_vec++;
        if (b128.out_data !== CT128A || b128.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_1: data=%h rdy=%b, expected %h/1", b128.out_data, b128.in_ready,
                     CT128A);
        end
        tick();
        b128.in_data = PT_A;
        b128.in_key  = K128_A;
        wait_out128(10, "b2b_2");
        n_vec++;
        if (b128.out_data !== CT128B) begin
            n_err++;
            $display("FAIL b2b_2 out_data: got %h, expected %h", b128.out_data, CT128B);
        end
        tick();
        b128.in_valid = 1'b0;
        wait_out128(10, "b2b_3");
        n_vec++;
        if (b128.out_data !== CT128A) begin
            n_err++;
            $display("FAIL b2b_3 out_data: got %h, expected %h", b128.out_data, CT128A);
        end
        tick();
        b128.out_ready = 1'b0;
        n_vec++;
        if (b128.out_valid !== 1'b0 || b128.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b end: vld=%b rdy=%b, expected 0/1", b128.out_valid, b128.in_ready);
        end
    endtask

    task automatic test_mid_reset();
        bit seen;
        b128.in_data  = PT_A;
        b128.in_key   = K128_A;
        b128.in_valid = 1'b1;
        tick();
        b128.in_valid = 1'b0;
        // Accept leaves rnd=1; four more rounds bring it to 5
        for (int i = 0; i < 4; i++) tick();
        n_vec++;
        if (b128.busy !== 1'b1 || b128.in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset pre: busy=%b rdy=%b, expected 1/0", b128.busy, b128.in_ready);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++;
        if (b128.in_ready !== 1'b1 || b128.out_valid !== 1'b0 || b128.busy !== 1'b0 ||
            b128.out_data !== 128'h0) begin
            n_err++;
            $display("FAIL mid_reset post: rdy=%b vld=%b busy=%b data=%h, expected 1/0/0/0",
                     b128.in_ready, b128.out_valid, b128.busy, b128.out_data);
        end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (b128.out_valid) seen = 1'b1;
        end
        n_vec++;
        if (seen !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset aborted block surfaced: out_valid seen=%b, expected 0", seen);
        end
        run128(PT_B, K128_B, CT128B, 1'b1, "after_reset");
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        clk   = 1'b0;
        reset = 1'b1;
        b128.in_valid = 1'b0; b128.in_data = '0; b128.in_key = '0; b128.out_ready = 1'b0;
        b192.in_valid = 1'b0; b192.in_data = '0; b192.in_key = '0; b192.out_ready = 1'b0;
        b256.in_valid = 1'b0; b256.in_data = '0; b256.in_key = '0; b256.out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        test_reset();
        test_aes128();
        test_aes192();
        test_aes256();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
